warp_scan_ctrl: RTL and testbench
=================================

# warp_scan_ctrl

Raster-scan sequencer for the wave-warp pixel datapath. On a frame-start trigger it walks an H_ACTIVE x V_ACTIVE source region in raster order and drives hcount/vcount/data_valid into the warp filter under a valid/ready handshake with the downstream frame-buffer writer. It then drains the filter pipeline, pulses frame-done, and advances a per-frame animation phase that the warp datapath uses as a horizontal offset.

## Interface
- H_ACTIVE, 240, pixels per line; hcount range 0..H_ACTIVE-1
- V_ACTIVE, 320, lines per frame; vcount range 0..V_ACTIVE-1
- PIPE_LAT, 2, warp datapath latency in cycles; drain length
- PHASE_DIV, 4, completed frames per phase step; must be >= 1

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- frame_start_in  input  1  single-cycle request to scan one frame
- enable_in  input  1  gates frame_start_in; sampled only in IDLE
- ready_in  input  1  downstream accepts the current beat
- hcount_out  output  11  current column
- vcount_out  output  10  current row
- data_valid_out  output  1  coordinate beat valid
- busy_out  output  1  high in any state except IDLE
- frame_done_out  output  1  one-cycle pulse at end of frame
- overrun_out  output  1  one-cycle pulse when frame_start_in arrives while busy
- phase_out  output  9  animation phase, 0..H_ACTIVE-1

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Reset (asserted at any time, including mid-frame): state goes to IDLE immediately. All outputs are 0. Frame counter and phase are 0.
- IDLE → SCAN when frame_start_in && enable_in. hcount and vcount are loaded with 0.
- SCAN:
  - data_valid_out = 1.
  - A beat transfers when data_valid_out && ready_in.
  - On a transfer, hcount increments. At H_ACTIVE-1 it wraps to 0 and vcount increments.
  - With ready_in low, hcount and vcount hold stable and valid stays high.
- Transfer of the last beat (H_ACTIVE-1, V_ACTIVE-1) → DRAIN.
  - data_valid_out drops to 0.
  - hcount and vcount hold the last coordinate.
- DRAIN: a counter runs PIPE_LAT cycles regardless of ready_in, then → DONE. With PIPE_LAT = 0, DRAIN lasts 1 cycle.
- DONE (1 cycle):
  - frame_done_out = 1.
  - Frame counter increments. At PHASE_DIV-1 it wraps to 0, and in the same cycle phase increments modulo H_ACTIVE (H_ACTIVE-1 → 0).
  - Next state is IDLE. hcount and vcount clear to 0.
- frame_start_in in SCAN, DRAIN or DONE is dropped, and overrun_out pulses the following cycle. frame_start_in in IDLE with enable_in low is dropped silently.
- Arithmetic is unsigned, and counters compare against parameter-1 in full width.

## Timing
- frame_start_in sampled high in IDLE at cycle N → data_valid_out high with (0,0) at cycle N+1.
- With ready_in held high, one beat transfers per cycle.
- Frame length from the first valid cycle to the frame_done_out cycle = H_ACTIVE·V_ACTIVE + max(PIPE_LAT,1) + 1 cycles. With defaults: 76800 + 2 + 1 = 76803.
- busy_out is registered. It rises with the first valid and falls the cycle after frame_done_out.
- phase_out updates on the cycle after the DONE cycle and is stable for the whole next frame.
- overrun_out and frame_done_out never assert in the same cycle as reset release.

## Configuration
- WARP_PHASE_EN defined: frame counter and phase logic are present, and phase_out behaves as above.
- WARP_PHASE_EN undefined: frame counter and phase registers are removed, and phase_out is tied to 0. All other behaviour and timing are identical.

## Test plan
- Reset/idle: hold rst_n_in low, then release with no start → all outputs 0 for 20 cycles.
- Full frame (H_ACTIVE=4, V_ACTIVE=3, PIPE_LAT=2), ready_in high, start at cycle 10:
  - Beats are (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2) on cycles 11–22.
  - frame_done_out pulses on cycle 25.
  - busy_out falls on cycle 26.
- Backpressure: as the full-frame case, with ready_in low every other cycle:
  - Coordinates hold while ready_in is low.
  - Exactly 12 transfers occur, with no skipped or duplicate coordinates.
  - frame_done_out pulses 3 cycles after the 12th transfer.
- Overrun and enable:
  - frame_start_in during SCAN → overrun_out pulses once, and the frame is unaffected.
  - frame_start_in in IDLE with enable_in=0 → no scan and no overrun.
- Phase (WARP_PHASE_EN, PHASE_DIV=2, H_ACTIVE=4):
  - Over 10 frames, phase_out reads 0,0,1,1,2,2,3,3,0,0 at each frame start.
  - With the macro undefined, phase_out stays 0.
- Async reset mid-SCAN at beat (2,1) → next edge shows IDLE with all outputs 0; a fresh start begins at (0,0).

Source files
------------

// File: rtl/warp_scan_ctrl.sv
// Raster-scan sequencer for the wave-warp datapath: scans H_ACTIVE x V_ACTIVE, drains, pulses done.
// Optional macro WARP_PHASE_EN adds the per-frame animation phase; otherwise phase_out is tied to 0.
module warp_scan_ctrl #(
  parameter int unsigned H_ACTIVE  = 240,
  parameter int unsigned V_ACTIVE  = 320,
  parameter int unsigned PIPE_LAT  = 2,
  parameter int unsigned PHASE_DIV = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        frame_start_in,
  input  logic        enable_in,
  input  logic        ready_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        overrun_out,
  output logic [8:0]  phase_out
);

  localparam int unsigned HW        = 11;
  localparam int unsigned VW        = 10;
  localparam int unsigned PW        = 9;
  localparam int unsigned DRAIN_LEN = (PIPE_LAT == 0) ? 1 : PIPE_LAT;
  localparam int unsigned DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_LEN - 1);

  if (PHASE_DIV < 1) begin : g_phase_div_chk
    $error("PHASE_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  // Next-state, coordinate and output decode
  always_comb begin
    state_d   = state_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    drain_d   = drain_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start_in && enable_in) begin
          state_d  = SCAN;
          hcount_d = '0;
          vcount_d = '0;
        end
      end
      SCAN: begin
        if (valid_q && ready_in) begin
          if (hcount_q == H_LAST) begin
            // Last beat keeps its coordinate visible through the drain
            if (vcount_q == V_LAST) begin
              state_d = DRAIN;
              drain_d = '0;
            end else begin
              hcount_d = '0;
              vcount_d = vcount_q + VW'(1);
            end
          end else begin
            hcount_d = hcount_q + HW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d  = IDLE;
        hcount_d = '0;
        vcount_d = '0;
      end
      default: state_d = IDLE;
    endcase
    valid_d   = (state_d == SCAN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    overrun_d = frame_start_in && (state_q != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      hcount_q  <= '0;
      vcount_q  <= '0;
      drain_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      drain_q   <= drain_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign hcount_out     = hcount_q;
  assign vcount_out     = vcount_q;
  assign data_valid_out = valid_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign overrun_out    = overrun_q;

`ifdef WARP_PHASE_EN
  localparam int unsigned   FW     = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(PHASE_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(H_ACTIVE - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] phase_q, phase_d;

  // Phase steps once every PHASE_DIV completed frames, wrapping at H_ACTIVE
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (state_q == DONE) begin
      if (frame_q == F_LAST) begin
        frame_d = '0;
        phase_d = (phase_q == P_LAST) ? '0 : phase_q + PW'(1);
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_q <= '0;
      phase_q <= '0;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign phase_out = phase_q;
`else
  assign phase_out = '0;
`endif

endmodule

// File: tb/tb_warp_scan_ctrl.sv
// Directed self-checking bench for warp_scan_ctrl with a 4x3 region, 2-cycle drain, phase step every 2 frames.
module tb_warp_scan_ctrl;

  logic        clk_in;
  logic        rst_n_in;
  logic        frame_start_in;
  logic        enable_in;
  logic        ready_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic        busy_out;
  logic        frame_done_out;
  logic        overrun_out;
  logic [8:0]  phase_out;

  int errors = 0;
  int checks = 0;

  warp_scan_ctrl #(
    .H_ACTIVE (4),
    .V_ACTIVE (3),
    .PIPE_LAT (2),
    .PHASE_DIV(2)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .frame_start_in(frame_start_in),
    .enable_in     (enable_in),
    .ready_in      (ready_in),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .data_valid_out(data_valid_out),
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out),
    .overrun_out   (overrun_out),
    .phase_out     (phase_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [33:0] all_outs();
    return {hcount_out, vcount_out, data_valid_out, busy_out,
            frame_done_out, overrun_out, phase_out};
  endfunction

  task automatic run_to_done(input string tag);
    int n = 0;
    while (frame_done_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (frame_done_out !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_done_out=%b after %0d cycles, required 1", tag, frame_done_out, n);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (all_outs() !== 34'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required 0", all_outs());
    end
    rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (all_outs() !== 34'd0) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: outputs=%h required 0", i, all_outs());
      end
    end
  endtask

  task automatic test_full_frame();
    ready_in = 1'b1;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (data_valid_out !== 1'b1 || busy_out !== 1'b1 || frame_done_out !== 1'b0 ||
          hcount_out !== 11'(k % 4) || vcount_out !== 10'(k / 4) || phase_out !== 9'd0) begin
        errors++;
        $display("FAIL full_beat %0d: v=%b busy=%b done=%b h=%0d vc=%0d ph=%0d required v=1 busy=1 done=0 h=%0d vc=%0d ph=0",
                 k, data_valid_out, busy_out, frame_done_out, hcount_out, vcount_out, phase_out, k % 4, k / 4);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (data_valid_out !== 1'b0 || busy_out !== 1'b1 || frame_done_out !== 1'b0 ||
          hcount_out !== 11'd3 || vcount_out !== 10'd2) begin
        errors++;
        $display("FAIL full_drain %0d: v=%b busy=%b done=%b h=%0d vc=%0d required v=0 busy=1 done=0 h=3 vc=2",
                 d, data_valid_out, busy_out, frame_done_out, hcount_out, vcount_out);
      end
      tick();
    end
    checks++;
    if (frame_done_out !== 1'b1 || busy_out !== 1'b1 || data_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL full_done: done=%b busy=%b v=%b required done=1 busy=1 v=0",
               frame_done_out, busy_out, data_valid_out);
    end
    tick();
    checks++;
    if (frame_done_out !== 1'b0 || busy_out !== 1'b0 || hcount_out !== 11'd0 ||
        vcount_out !== 10'd0 || phase_out !== 9'd0) begin
      errors++;
      $display("FAIL full_after_done: done=%b busy=%b h=%0d vc=%0d ph=%0d required all 0",
               frame_done_out, busy_out, hcount_out, vcount_out, phase_out);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int last_xfer = -1;
    int done_cyc = -1;
    frame_start_in = 1'b1;
    ready_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      ready_in = (c % 2 == 1);
      if (frame_done_out === 1'b1) done_cyc = c;
      if (data_valid_out === 1'b1) begin
        checks++;
        if (idx >= 12 || hcount_out !== 11'(idx % 4) || vcount_out !== 10'(idx / 4)) begin
          errors++;
          $display("FAIL bp_beat %0d: h=%0d vc=%0d required h=%0d vc=%0d (max 12 beats)",
                   idx, hcount_out, vcount_out, idx % 4, idx / 4);
        end
        if (ready_in) begin
          idx++;
          last_xfer = c;
        end
      end
      tick();
    end
    ready_in = 1'b1;
    checks++;
    if (idx != 12) begin
      errors++;
      $display("FAIL bp_transfers: got %0d required 12", idx);
    end
    checks++;
    if (done_cyc != last_xfer + 3) begin
      errors++;
      $display("FAIL bp_done_latency: done at %0d last transfer at %0d, required last+3", done_cyc, last_xfer);
    end
    tick();
  endtask

  task automatic test_overrun_enable();
    ready_in = 1'b1;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    tick();
    tick();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    checks++;
    if (overrun_out !== 1'b1 || hcount_out !== 11'd3 || vcount_out !== 10'd0 || data_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: ovr=%b h=%0d vc=%0d v=%b required ovr=1 h=3 vc=0 v=1",
               overrun_out, hcount_out, vcount_out, data_valid_out);
    end
    for (int k = 4; k < 12; k++) begin
      tick();
      checks++;
      if (overrun_out !== 1'b0 || hcount_out !== 11'(k % 4) || vcount_out !== 10'(k / 4)) begin
        errors++;
        $display("FAIL ovr_frame beat %0d: ovr=%b h=%0d vc=%0d required ovr=0 h=%0d vc=%0d",
                 k, overrun_out, hcount_out, vcount_out, k % 4, k / 4);
      end
    end
    repeat (3) tick();
    checks++;
    if (frame_done_out !== 1'b1) begin
      errors++;
      $display("FAIL ovr_done: done=%b required 1", frame_done_out);
    end
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    checks++;
    if (overrun_out !== 1'b1 || busy_out !== 1'b0 || data_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL ovr_in_done: ovr=%b busy=%b v=%b required ovr=1 busy=0 v=0",
               overrun_out, busy_out, data_valid_out);
    end
    tick();
    checks++;
    if (overrun_out !== 1'b0 || busy_out !== 1'b0 || data_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL ovr_dropped: ovr=%b busy=%b v=%b required all 0", overrun_out, busy_out, data_valid_out);
    end
    enable_in = 1'b0;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_out !== 1'b0 || data_valid_out !== 1'b0 || overrun_out !== 1'b0) begin
        errors++;
        $display("FAIL enable_low cycle %0d: busy=%b v=%b ovr=%b required all 0",
                 i, busy_out, data_valid_out, overrun_out);
      end
      tick();
    end
    enable_in = 1'b1;
  endtask

  task automatic test_async_reset();
    ready_in = 1'b1;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    repeat (6) tick();
    checks++;
    if (hcount_out !== 11'd2 || vcount_out !== 10'd1 || data_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: h=%0d vc=%0d v=%b required h=2 vc=1 v=1", hcount_out, vcount_out, data_valid_out);
    end
    rst_n_in = 1'b0;
    #2;
    checks++;
    if (all_outs() !== 34'd0) begin
      errors++;
      $display("FAIL arst_immediate: outputs=%h required 0", all_outs());
    end
    tick();
    checks++;
    if (all_outs() !== 34'd0) begin
      errors++;
      $display("FAIL arst_edge: outputs=%h required 0", all_outs());
    end
    rst_n_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (all_outs() !== 34'd0) begin
        errors++;
        $display("FAIL arst_release cycle %0d: outputs=%h required 0", i, all_outs());
      end
    end
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    checks++;
    if (data_valid_out !== 1'b1 || hcount_out !== 11'd0 || vcount_out !== 10'd0 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL arst_restart: v=%b h=%0d vc=%0d busy=%b required v=1 h=0 vc=0 busy=1",
               data_valid_out, hcount_out, vcount_out, busy_out);
    end
    run_to_done("arst_frame");
    tick();
  endtask

  task automatic test_phase();
    logic [8:0] exp_phase;
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    ready_in = 1'b1;
    for (int f = 0; f < 10; f++) begin
`ifdef WARP_PHASE_EN
      exp_phase = 9'((f / 2) % 4);
`else
      exp_phase = 9'd0;
`endif
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      checks++;
      if (phase_out !== exp_phase || data_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL phase frame %0d: phase=%0d v=%b required phase=%0d v=1",
                 f, phase_out, data_valid_out, exp_phase);
      end
      run_to_done("phase_frame");
      tick();
    end
  endtask

  initial begin
    rst_n_in       = 1'b0;
    frame_start_in = 1'b0;
    enable_in      = 1'b1;
    ready_in       = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_overrun_enable();
    test_async_reset();
    test_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
